ml_matvec_engine: RTL
=====================

# ml_matvec_engine

Synthesizable signed integer matrix-vector multiply engine.
- Loads an N-element vector, then consumes a row-major matrix stream and emits one dot product per row.
- It is the hardware counterpart of the MathLib vector/matrix package: the package's matrix-vector routines are the bench's golden model for this block.
- It sits behind a stream source (DMA or testbench driver) and feeds a result sink. Every port uses valid/ready.

## Interface
- DW, 16: signed element width (vector and matrix).
- N, 4: vector length = matrix columns, N ≥ 2.
- OW, 2*DW+$clog2(N): result width (derived, not overridden).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a job when idle.
- busy  out  1  high from accepted start until final result handshake.
- s_vec_valid / s_vec_ready  in / out  1 / 1  vector element handshake.
- s_vec_data  in  DW  signed vector element, index 0 first.
- s_mat_valid / s_mat_ready  in / out  1 / 1  matrix element handshake.
- s_mat_data  in  DW  signed matrix element, row-major.
- s_mat_last  in  1  marks final element of whole matrix.
- m_res_valid / m_res_ready  out / in  1 / 1  result handshake.
- m_res_data  out  OW  signed row dot product.
- m_res_last  out  1  marks result of final row.
- err  out  1  sticky; s_mat_last seen off a row boundary.
- sat  out  1  sticky; a result was clamped (SAT build only).

## Operation
- States: IDLE, LOAD, RUN, DRAIN.
- IDLE
  - start → LOAD; clears err, sat and all counters.
  - start while busy is ignored.
- LOAD
  - s_vec_ready=1; each handshake writes vec[idx], idx++.
  - After N handshakes → RUN.
- RUN
  - s_mat_ready = !m_res_valid || m_res_ready (one-entry output buffer).
  - Each handshake: acc += s_mat_data * vec[col], full OW signed precision; col++.
- Row end (col==N-1 accepted)
  - Result register loads acc + product; m_res_valid=1; acc and col return to 0.
- s_mat_last with col==N-1
  - Result carries m_res_last=1; → DRAIN.
- s_mat_last with col≠N-1
  - Partial sum is emitted as the final result with m_res_last=1; err=1; → DRAIN.
- DRAIN: on m_res_valid && m_res_ready → IDLE; busy drops the same edge.
- m_res_data, m_res_last are held stable while m_res_valid && !m_res_ready.
- Reset (any state, including mid-row)
  - State IDLE; all outputs 0; accumulator, counters and vector registers 0.

## Timing
- Accumulate stage: 1 cycle.
- m_res_valid rises the cycle after the row's last element handshake.
- Back-to-back rows at full throughput (1 element/cycle) when m_res_ready is held high.
- s_vec_ready is 0 outside LOAD; s_mat_ready is 0 outside RUN.
- A result consumed in the same cycle a new row completes is replaced without a bubble.

## Configuration
- ML_MATVEC_SAT_EN defined
  - Each result is clamped to [-2^(DW-1), 2^(DW-1)-1], sign-extended to OW.
  - sat is set sticky on any clamp.
- ML_MATVEC_SAT_EN undefined
  - Full-precision OW result; sat tied 0.

## Structure
- Shared package ml_hw_pkg holds:
  - state enum (IDLE/LOAD/RUN/DRAIN)
  - default DW/N constants
  - function for OW
  - saturate function
- Sub-module ml_mac: signed multiply-accumulate with clear and enable, parameterized DW and OW; instantiated once.

## Test plan
- Basic dot product: N=4, vec=[1,2,3,4], one row [1,1,1,1] with last → single result 10, m_res_last=1, err=0, then busy=0.
- Identity matrix: vec=[5,-6,7,-8], 4×4 identity with last on element 16 → results 5, -6, 7, -8; last only on the 4th.
- Overflow, vec and row all 32767:
  - SAT build → 32767, sat=1.
  - Non-SAT build → 4294705156, sat=0.
- Backpressure: m_res_ready low for 5 cycles after the first row → s_mat_ready=0 throughout, m_res_data stable, no element lost; the next row's result follows.
- Early last on the 2nd element of row 0, vec=[1,1,1,1], data [3,4] → result 7, m_res_last=1, err=1.
- Reset mid-RUN: rst_n low after 2 matrix elements → busy, m_res_valid, err=0 immediately; a new start reloads cleanly and reproduces the basic dot-product case.

Source files
------------

// File: rtl/ml_hw_pkg.sv
// Shared types, default sizes and arithmetic helpers for the matrix-vector engine.
// Consumers: ml_mac and ml_matvec_engine (optional clamp enabled by ML_MATVEC_SAT_EN).
package ml_hw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int DEFAULT_DW = 16;
  localparam int DEFAULT_N  = 4;

  // Sum of N products of two DW-bit signed values needs clog2(N) guard bits.
  function automatic int calcOw(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic logic signed [63:0] satClamp(input logic signed [63:0] value,
                                                  input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/ml_mac.sv
// Signed multiply-accumulate: sum_o = acc + a*b combinationally; the accumulator
// registers sum_o on en_i, and clear_i (higher priority) returns it to zero.
module ml_mac #(
  parameter int DW = 16,
  parameter int OW = 34
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  output logic signed [OW-1:0] sum_o
);

  logic signed [2*DW-1:0] prod;
  logic signed [OW-1:0]   acc_q;
  logic signed [OW-1:0]   acc_d;

  assign prod  = a_i * b_i;
  assign sum_o = acc_q + $signed({{(OW-2*DW){prod[2*DW-1]}}, prod});

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = sum_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/ml_matvec_engine.sv
// Streaming signed matrix-vector engine: loads an N-element vector, then emits one
// dot product per matrix row. Define ML_MATVEC_SAT_EN to clamp results to DW range.
module ml_matvec_engine
  import ml_hw_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int N  = DEFAULT_N
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  output logic                               busy,
  input  logic                               s_vec_valid,
  output logic                               s_vec_ready,
  input  logic signed [DW-1:0]               s_vec_data,
  input  logic                               s_mat_valid,
  output logic                               s_mat_ready,
  input  logic signed [DW-1:0]               s_mat_data,
  input  logic                               s_mat_last,
  output logic                               m_res_valid,
  input  logic                               m_res_ready,
  output logic signed [calcOw(DW,N)-1:0]     m_res_data,
  output logic                               m_res_last,
  output logic                               err,
  output logic                               sat
);

  localparam int OW = calcOw(DW, N);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_COL = CW'(N - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        col_q, col_d;
  logic signed [DW-1:0] vec_q [N];
  logic                 resValid_q, resValid_d;
  logic                 resLast_q, resLast_d;
  logic signed [OW-1:0] resData_q, resData_d;
  logic                 err_q, err_d;

  logic                 startAcc;
  logic                 vecHs;
  logic                 matHs;
  logic                 rowEnd;
  logic                 emit;
  logic                 resHs;
  logic signed [OW-1:0] macSum;
  logic signed [OW-1:0] resNext;

  assign startAcc    = (state_q == IDLE) && start;
  assign s_vec_ready = (state_q == LOAD);
  assign vecHs       = s_vec_ready && s_vec_valid;
  // One-entry output buffer: a row may complete whenever the buffer is empty or draining.
  assign s_mat_ready = (state_q == RUN) && (!resValid_q || m_res_ready);
  assign matHs       = s_mat_ready && s_mat_valid;
  assign rowEnd      = matHs && (col_q == LAST_COL);
  assign emit        = rowEnd || (matHs && s_mat_last);
  assign resHs       = resValid_q && m_res_ready;

  ml_mac #(
    .DW (DW),
    .OW (OW)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (startAcc || emit),
    .en_i    (matHs),
    .a_i     (s_mat_data),
    .b_i     (vec_q[col_q]),
    .sum_o   (macSum)
  );

`ifdef ML_MATVEC_SAT_EN
  logic sat_q, sat_d;
  logic clamped;

  always_comb begin
    resNext = OW'(satClamp(64'(macSum), DW));
    clamped = (resNext != macSum);
    sat_d   = sat_q;
    if (startAcc) begin
      sat_d = 1'b0;
    end else if (emit && clamped) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat = sat_q;
`else
  assign resNext = macSum;
  assign sat     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    col_d      = col_q;
    err_d      = err_q;
    resValid_d = resValid_q;
    resData_d  = resData_q;
    resLast_d  = resLast_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
          col_d   = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (vecHs) begin
          if (idx_q == LAST_COL) begin
            idx_d   = '0;
            state_d = RUN;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      RUN: begin
        if (matHs) begin
          col_d = emit ? '0 : col_q + CW'(1);
          if (s_mat_last) begin
            state_d = DRAIN;
            if (!rowEnd) err_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (resHs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new row result overwrites a buffered one only when that one is consumed this cycle.
    if (emit) begin
      resValid_d = 1'b1;
      resData_d  = resNext;
      resLast_d  = s_mat_last;
    end else if (resHs) begin
      resValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      col_q      <= '0;
      err_q      <= 1'b0;
      resValid_q <= 1'b0;
      resData_q  <= '0;
      resLast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      col_q      <= col_d;
      err_q      <= err_d;
      resValid_q <= resValid_d;
      resData_q  <= resData_d;
      resLast_q  <= resLast_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) vec_q[i] <= '0;
    end else if (vecHs) begin
      vec_q[idx_q] <= s_vec_data;
    end
  end

  assign busy        = (state_q != IDLE);
  assign m_res_valid = resValid_q;
  assign m_res_data  = resData_q;
  assign m_res_last  = resLast_q;
  assign err         = err_q;

endmodule
